result_frame_buffer: RTL and testbench

Output-side frame store for the 3x3 window filter datapath. It accepts the raster stream of filter results, one per 3x3 window, and clamps each signed result to an 8-bit pixel. It stores one complete ROWS x COLS frame, then streams that frame out in raster order over a valid/ready handshake. It is the write-back end of the window memory: the window memory emits neighbourhoods, and this block collects the results and hands them downstream.

---
 rtl/result_frame_buffer.sv | 144 ++++++++++++++
 tb/tb_result_frame_buffer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/result_frame_buffer.sv
// rtl/result_frame_buffer.sv - clamps signed filter results into an 8-bit frame store and streams the frame out
module result_frame_buffer #(
  parameter int IN_W = 12,
  parameter int COLS = 64,
  parameter int ROWS = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [IN_W-1:0] in_data,
  output logic            in_ready,
  output logic            out_valid,
  output logic [7:0]      out_pixel,
  output logic            out_last,
  input  logic            out_ready,
  output logic            sat_pulse,
  output logic            frame_done,
  output logic [7:0]      frame_cnt
);

  localparam int DEPTH = ROWS * COLS;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  localparam logic [1:0] ST_FILL  = 2'd0;
  localparam logic [1:0] ST_PRIME = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [7:0] mem [DEPTH];

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    out_pixel_q, out_pixel_d;
  logic          out_last_q, out_last_d;
  logic          sat_pulse_q, sat_pulse_d;
  logic          frame_done_q, frame_done_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;

  logic       accept;
  logic       handshake;
  logic       is_neg;
  logic       is_over;
  logic [7:0] clamped;

  assign in_ready  = (state_q == ST_FILL) & rst_n;
  assign accept    = in_valid & in_ready;
  assign handshake = out_valid_q & out_ready;

  // Anything non-negative with a set bit above bit 7 exceeds 255 (IN_W >= 10).
  assign is_neg  = in_data[IN_W-1];
  assign is_over = ~is_neg & (|in_data[IN_W-2:8]);
  assign clamped = is_neg ? 8'h00 : (is_over ? 8'hFF : in_data[7:0]);

  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    out_valid_d  = out_valid_q;
    out_pixel_d  = out_pixel_q;
    out_last_d   = out_last_q;
    sat_pulse_d  = 1'b0;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    case (state_q)
      ST_FILL: begin
        if (accept) begin
          sat_pulse_d = is_neg | is_over;
          if (wr_addr_q == LAST_ADDR) begin
            wr_addr_d = '0;
            state_d   = ST_PRIME;
          end else begin
            wr_addr_d = wr_addr_q + 1'b1;
          end
        end
      end
      ST_PRIME: begin
        out_pixel_d = mem[0];
        rd_addr_d   = AW'(1);
        out_valid_d = 1'b1;
        out_last_d  = (LAST_ADDR == '0);
        state_d     = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (handshake) begin
          if (out_last_q) begin
            out_valid_d  = 1'b0;
            out_last_d   = 1'b0;
            rd_addr_d    = '0;
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 8'd1;
            state_d      = ST_FILL;
          end else begin
            // rd_addr always points one ahead of the presented pixel, so no bubble.
            out_pixel_d = mem[rd_addr_q];
            out_last_d  = (rd_addr_q == LAST_ADDR);
            rd_addr_d   = (rd_addr_q == LAST_ADDR) ? '0 : rd_addr_q + 1'b1;
          end
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_FILL;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      out_valid_q  <= 1'b0;
      out_pixel_q  <= 8'h00;
      out_last_q   <= 1'b0;
      sat_pulse_q  <= 1'b0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      out_valid_q  <= out_valid_d;
      out_pixel_q  <= out_pixel_d;
      out_last_q   <= out_last_d;
      sat_pulse_q  <= sat_pulse_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  // Frame storage is deliberately not reset; accept is already gated by rst_n.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_addr_q] <= clamped;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_pixel  = out_pixel_q;
  assign out_last   = out_last_q;
  assign sat_pulse  = sat_pulse_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_result_frame_buffer.sv
// tb/tb_result_frame_buffer.sv - directed bench for result_frame_buffer (64x64 frame plus a 4x4 wrap instance)
module tb_result_frame_buffer;

  localparam int N = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [11:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_pixel;
  logic        out_last;
  logic        out_ready;
  logic        sat_pulse;
  logic        frame_done;
  logic [7:0]  frame_cnt;

  logic        s_rst_n;
  logic        s_in_valid;
  logic [11:0] s_in_data;
  logic        s_in_ready;
  logic        s_out_valid;
  logic [7:0]  s_out_pixel;
  logic        s_out_last;
  logic        s_out_ready;
  logic        s_sat_pulse;
  logic        s_frame_done;
  logic [7:0]  s_frame_cnt;

  int tests  = 0;
  int fails  = 0;
  int sat_cnt  = 0;
  int done_cnt = 0;
  int vals [N];
  int expv [N];

  always #5 clk = ~clk;

  result_frame_buffer #(.IN_W(12), .COLS(64), .ROWS(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_pixel(out_pixel), .out_last(out_last), .out_ready(out_ready),
    .sat_pulse(sat_pulse), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  result_frame_buffer #(.IN_W(12), .COLS(4), .ROWS(4)) dut_small (
    .clk(clk), .rst_n(s_rst_n), .in_valid(s_in_valid), .in_data(s_in_data), .in_ready(s_in_ready),
    .out_valid(s_out_valid), .out_pixel(s_out_pixel), .out_last(s_out_last), .out_ready(s_out_ready),
    .sat_pulse(s_sat_pulse), .frame_done(s_frame_done), .frame_cnt(s_frame_cnt)
  );

  always @(negedge clk) begin
    if (sat_pulse) sat_cnt++;
    if (frame_done) done_cnt++;
  end

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int clamp8(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  task automatic set_ramp();
    for (int k = 0; k < N; k++) begin
      vals[k] = k % 256;
      expv[k] = k % 256;
    end
  endtask

  task automatic fill(input int n, input bit gaps, input bit full);
    for (int k = 0; k < n; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
      end
      in_valid = 1'b1;
      in_data  = vals[k][11:0];
      check("in_ready_fill", int'(in_ready), 1);
      tick();
    end
    in_valid = 1'b0;
    if (full) begin
      check("prime_out_valid", int'(out_valid), 0);
      check("prime_in_ready", int'(in_ready), 0);
      tick();
      check("first_out_valid", int'(out_valid), 1);
    end
  endtask

  task automatic drain(input int stop, input bit stall, input int exp_cnt);
    int idx = 0;
    int cyc = 0;
    bit hs;
    logic [7:0] prev;
    while (idx < stop && cyc < 4 * N + 100) begin
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      check("drain_in_ready", int'(in_ready), 0);
      check("drain_valid", int'(out_valid), 1);
      check("drain_pixel", int'(out_pixel), expv[idx]);
      check("drain_last", int'(out_last), (idx == N - 1) ? 1 : 0);
      prev = out_pixel;
      hs = out_ready;
      tick();
      cyc++;
      if (hs) idx++;
      else check("stall_stable", int'(out_pixel), int'(prev));
    end
    out_ready = 1'b0;
    if (idx < stop) check("drain_timeout", idx, stop);
    if (stop == N) begin
      check("frame_done_pulse", int'(frame_done), 1);
      check("end_out_valid", int'(out_valid), 0);
      check("end_out_last", int'(out_last), 0);
      check("end_in_ready", int'(in_ready), 1);
      check("frame_cnt", int'(frame_cnt), exp_cnt);
      tick();
      check("frame_done_one_cycle", int'(frame_done), 0);
    end
  endtask

  initial begin
    int s0;
    int d0;
    rst_n = 1'b0; in_valid = 1'b1; in_data = 12'd0; out_ready = 1'b0;
    s_rst_n = 1'b0; s_in_valid = 1'b0; s_in_data = 12'd0; s_out_ready = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_pixel", int'(out_pixel), 0);
    check("rst_frame_cnt", int'(frame_cnt), 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    s_rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", int'(in_ready), 1);
    check("post_rst_out_valid", int'(out_valid), 0);

    // Clamp frame: six edge values then the ramp.
    set_ramp();
    vals[0] = -5; vals[1] = 0; vals[2] = 128; vals[3] = 255; vals[4] = 256; vals[5] = 2047;
    expv[0] = 0;  expv[1] = 0; expv[2] = 128; expv[3] = 255; expv[4] = 255; expv[5] = 255;
    for (int k = 0; k < 6; k++) check("clamp_model", clamp8(vals[k]), expv[k]);
    s0 = sat_cnt;
    fill(N, 1'b0, 1'b1);
    check("sat_count_clamp", sat_cnt - s0, 3);
    drain(N, 1'b0, 1);

    set_ramp();
    s0 = sat_cnt;
    fill(N, 1'b0, 1'b1);
    check("sat_count_ramp", sat_cnt - s0, 0);
    drain(N, 1'b0, 2);

    fill(N, 1'b1, 1'b1);
    drain(N, 1'b1, 3);

    // Reset after 1000 accepts, then a full 0x5A frame.
    fill(1000, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    check("midfill_rst_in_ready", int'(in_ready), 0);
    check("midfill_rst_frame_cnt", int'(frame_cnt), 0);
    rst_n = 1'b1;
    #1;
    check("midfill_release_in_ready", int'(in_ready), 1);
    for (int k = 0; k < N; k++) begin
      vals[k] = 'h5A;
      expv[k] = 'h5A;
    end
    fill(N, 1'b0, 1'b1);
    drain(N, 1'b0, 1);

    // Reset during drain at pixel 2000.
    set_ramp();
    fill(N, 1'b0, 1'b1);
    d0 = done_cnt;
    drain(2000, 1'b0, 0);
    check("middrain_pixel2000", int'(out_pixel), 2000 % 256);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("middrain_no_done", done_cnt - d0, 0);
    check("middrain_frame_cnt", int'(frame_cnt), 0);
    check("middrain_out_valid", int'(out_valid), 0);
    check("middrain_in_ready", int'(in_ready), 1);
    for (int k = 0; k < N; k++) begin
      vals[k] = (k * 7 + 3) % 256;
      expv[k] = (k * 7 + 3) % 256;
    end
    fill(N, 1'b0, 1'b1);
    drain(N, 1'b0, 1);

    // 256 frames on the 4x4 instance: counter and address wrap.
    for (int f = 0; f < 256; f++) begin
      for (int k = 0; k < 16; k++) begin
        s_in_valid = 1'b1;
        s_in_data  = 12'((f + k) % 256);
        if (k == 0) check("s_in_ready", int'(s_in_ready), 1);
        tick();
      end
      s_in_valid = 1'b0;
      tick();
      tick();
      for (int k = 0; k < 16; k++) begin
        check("s_valid", int'(s_out_valid), 1);
        check("s_pixel", int'(s_out_pixel), (f + k) % 256);
        check("s_last", int'(s_out_last), (k == 15) ? 1 : 0);
        s_out_ready = 1'b1;
        tick();
      end
      s_out_ready = 1'b0;
      check("s_frame_done", int'(s_frame_done), 1);
      check("s_frame_cnt", int'(s_frame_cnt), (f + 1) % 256);
    end
    check("s_frame_cnt_wrapped", int'(s_frame_cnt), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
